// File: rtl/la_odiff_ser.sv
// ============================================================================
//  Module      : la_odiff_ser
//  Description : Differential serial transmit lane. Accepts parallel words on
//                a valid/ready handshake and sends them LSB-first, framed by
//                a start bit (0) and a stop bit (1), on a complementary pad
//                pair z/zb. After enable, a 1,0,1,0... training preamble lets
//                the far-end receiver settle before any data.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PROP    implementation property string, passed through for library mapping
//    DW      data word width (1..32)
//    NTRAIN  training preamble length in cycles (1..255)
//  Ports
//    clk     clock, one bit per cycle
//    reset   asynchronous, active-high reset
//    en      lane enable; low forces the off state (z=0, zb=0)
//    din     parallel data word
//    valid   din is valid
//    ready   lane accepts din this cycle (transfer on valid & ready)
//    busy    frame or training in progress
//    z, zb   positive / negative pad drive
//  Build option
//    LA_ODIFF_PARITY_EN  when defined, an even-parity bit is sent between the
//                        last data bit and the stop bit
// ============================================================================
`default_nettype none

module la_odiff_ser #(
    parameter        PROP   = "DEFAULT",
    parameter int    DW     = 8,
    parameter int    NTRAIN = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic          valid,
    output logic          ready,
    output logic          busy,
    output logic          z,
    output logic          zb
);

    localparam int BW = $clog2(DW + 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_TRAIN  = 3'd1,
        S_IDLE   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
        S_PARITY = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    tcnt, tcnt_nxt;
    logic [BW-1:0] bcnt, bcnt_nxt;
    logic [DW-1:0] shreg, shreg_nxt;
    logic          z_nxt;
    logic          zb_nxt;
    logic          ready_nxt;
    logic          busy_nxt;
    logic          ready_q;
    logic          accept;
`ifdef LA_ODIFF_PARITY_EN
    logic          par, par_nxt;
`endif

    // PROP only matters to library mapping; nothing in the logic depends on it.
    generate
        if (PROP == "") begin : g_prop_unmapped
        end
    endgenerate

    // The registered ready is gated by en so the lane never offers to take a
    // word in a cycle where the enable is already low (that word would be lost
    // to the abort on the next edge).
    assign ready  = ready_q & en;
    assign accept = valid & ready;

    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        bcnt_nxt  = bcnt;
        shreg_nxt = shreg;
        z_nxt     = 1'b0;
`ifdef LA_ODIFF_PARITY_EN
        par_nxt   = par;
`endif
        if (!en) begin
            // Abort: drop any partial frame and park the pads at 0/0.
            state_nxt = S_OFF;
            tcnt_nxt  = 8'd0;
            bcnt_nxt  = '0;
            shreg_nxt = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = S_TRAIN;
                    tcnt_nxt  = 8'd0;
                    z_nxt     = 1'b1;
                end
                S_TRAIN: begin
                    if (tcnt == 8'(NTRAIN - 1)) begin
                        state_nxt = S_IDLE;
                        tcnt_nxt  = 8'd0;
                        z_nxt     = 1'b1;
                    end else begin
                        // Preamble bit k is ~k[0]; bit k+1 is therefore k[0].
                        tcnt_nxt = tcnt + 8'd1;
                        z_nxt    = tcnt[0];
                    end
                end
                S_IDLE, S_STOP: begin
                    // Accepting during STOP starts the next frame with no gap.
                    if (accept) begin
                        state_nxt = S_START;
                        shreg_nxt = din;
`ifdef LA_ODIFF_PARITY_EN
                        par_nxt   = ^din;
`endif
                        z_nxt     = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                        z_nxt     = 1'b1;
                    end
                end
                S_START: begin
                    state_nxt = S_DATA;
                    bcnt_nxt  = '0;
                    z_nxt     = shreg[0];
                    shreg_nxt = shreg >> 1;
                end
                S_DATA: begin
                    if (bcnt == BW'(DW - 1)) begin
                        bcnt_nxt  = '0;
`ifdef LA_ODIFF_PARITY_EN
                        state_nxt = S_PARITY;
                        z_nxt     = par;
`else
                        state_nxt = S_STOP;
                        z_nxt     = 1'b1;
`endif
                    end else begin
                        bcnt_nxt  = bcnt + BW'(1);
                        z_nxt     = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
                S_PARITY: begin
                    state_nxt = S_STOP;
                    z_nxt     = 1'b1;
                end
                default: begin
                    state_nxt = S_OFF;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so every pad level is a flop.
    always_comb begin
        zb_nxt    = (state_nxt == S_OFF) ? 1'b0 : ~z_nxt;
        ready_nxt = (state_nxt == S_IDLE) || (state_nxt == S_STOP);
        busy_nxt  = (state_nxt != S_OFF) && (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_OFF;
            tcnt    <= 8'd0;
            bcnt    <= '0;
            shreg   <= '0;
            z       <= 1'b0;
            zb      <= 1'b0;
            ready_q <= 1'b0;
            busy    <= 1'b0;
`ifdef LA_ODIFF_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            tcnt    <= tcnt_nxt;
            bcnt    <= bcnt_nxt;
            shreg   <= shreg_nxt;
            z       <= z_nxt;
            zb      <= zb_nxt;
            ready_q <= ready_nxt;
            busy    <= busy_nxt;
`ifdef LA_ODIFF_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

endmodule

`default_nettype wire
